// File: rtl/axi_stream_extract_header.sv
// ---------------------------------------------------------------------------
// axi_stream_extract_header
//
// Strips a per-packet header of H bytes (0..DATA_BYTE_WD) from the front of an
// AXI Stream packet. The header goes out on m00, right-aligned (valid bytes in
// the low lanes). The remaining payload is re-packed MSB-aligned on m01, with
// tkeep contiguous from the MSB.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s_cfg_*                    header length H per packet, accepted only in IDLE
//   s_axis_*                   packet in (tkeep full except on the last beat)
//   m00_axis_*                 header beat out (one per packet when H > 0)
//   m01_axis_*                 payload beats out
//   hdr_err                    one-cycle pulse: packet shorter than H bytes
//
// Byte lane i of a beat lives in tdata[8*i +: 8] and is qualified by tkeep[i];
// the first byte of the stream is the MSB lane.
// ---------------------------------------------------------------------------
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    s_cfg_tvalid,
    input  logic [LEN_WD-1:0]       s_cfg_tdata,
    output logic                    s_cfg_tready,

    input  logic                    s_axis_tvalid,
    input  logic [DATA_WD-1:0]      s_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,

    output logic                    m00_axis_tvalid,
    output logic [DATA_WD-1:0]      m00_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m00_axis_tkeep,
    input  logic                    m00_axis_tready,

    output logic                    m01_axis_tvalid,
    output logic [DATA_WD-1:0]      m01_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m01_axis_tkeep,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,

    output logic                    hdr_err
);

    localparam logic [LEN_WD-1:0] FULL_LEN = LEN_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY, ST_FLUSH} state_t;

    function automatic logic [LEN_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] keep);
        logic [LEN_WD-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) cnt = cnt + LEN_WD'(keep[i]);
        return cnt;
    endfunction

    // cnt ones packed against the MSB lane (payload tkeep)
    function automatic logic [DATA_BYTE_WD-1:0] ones_msb(input logic [LEN_WD-1:0] cnt);
        return ~({DATA_BYTE_WD{1'b1}} >> cnt);
    endfunction

    // cnt ones packed against the LSB lane (header tkeep)
    function automatic logic [DATA_BYTE_WD-1:0] ones_lsb(input logic [LEN_WD-1:0] cnt);
        return ~({DATA_BYTE_WD{1'b1}} << cnt);
    endfunction

    function automatic logic [DATA_WD-1:0] keep_to_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] mask;
        for (int i = 0; i < DATA_BYTE_WD; i++) mask[8*i +: 8] = {8{keep[i]}};
        return mask;
    endfunction

    function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] data,
                                                     input int unsigned nb);
        return data << (8 * nb);
    endfunction

    function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] data,
                                                     input int unsigned nb);
        return data >> (8 * nb);
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [LEN_WD-1:0]       r_hlen, w_hlen_nxt;
    logic [LEN_WD-1:0]       r_flush_len, w_flush_len_nxt;
    // Residual buffer: bytes left over from the previous beat, kept MSB-aligned
    logic [DATA_WD-1:0]      r_resid;
    logic                    r_hdr_err, w_hdr_err_nxt;

    logic                    r_m00_valid;
    logic [DATA_WD-1:0]      r_m00_data;
    logic [DATA_BYTE_WD-1:0] r_m00_keep;
    logic                    r_m01_valid, r_m01_last;
    logic [DATA_WD-1:0]      r_m01_data;
    logic [DATA_BYTE_WD-1:0] r_m01_keep;

    logic                    w_m00_free, w_m01_free, w_pass, w_s_hs;
    logic [LEN_WD-1:0]       w_n, w_hm, w_rlen, w_cfg_len;
    logic [DATA_WD-1:0]      w_din;

    logic                    w_resid_load, w_m00_load, w_m01_load, w_m01_last;
    logic [DATA_WD-1:0]      w_resid_nxt, w_m00_data, w_m01_data;
    logic [DATA_BYTE_WD-1:0] w_m00_keep, w_m01_keep;

    assign w_m00_free = !r_m00_valid || m00_axis_tready;
    assign w_m01_free = !r_m01_valid || m01_axis_tready;
    assign w_n        = popcount(s_axis_tkeep);
    assign w_hm       = (w_n < r_hlen) ? w_n : r_hlen;
    assign w_rlen     = FULL_LEN - r_hlen;
    // H = 0 and H = full beat both need no byte re-alignment in the body
    assign w_pass     = (r_hlen == '0) || (r_hlen == FULL_LEN);
    assign w_cfg_len  = (s_cfg_tdata > FULL_LEN) ? FULL_LEN : s_cfg_tdata;
    // Unqualified lanes are zeroed on entry so every shifted product is clean
    assign w_din      = s_axis_tdata & keep_to_mask(s_axis_tkeep);
    assign w_s_hs     = s_axis_tvalid && s_axis_tready;

    assign s_cfg_tready    = (r_state == ST_IDLE);
    assign m00_axis_tvalid = r_m00_valid;
    assign m00_axis_tdata  = r_m00_data;
    assign m00_axis_tkeep  = r_m00_keep;
    assign m01_axis_tvalid = r_m01_valid;
    assign m01_axis_tdata  = r_m01_data;
    assign m01_axis_tkeep  = r_m01_keep;
    assign m01_axis_tlast  = r_m01_last;
    assign hdr_err         = r_hdr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt     = r_state;
        w_hlen_nxt      = r_hlen;
        w_flush_len_nxt = r_flush_len;
        w_hdr_err_nxt   = 1'b0;
        s_axis_tready   = 1'b0;
        w_resid_load    = 1'b0;
        w_resid_nxt     = shl_bytes(w_din, 32'(r_hlen));
        w_m00_load      = 1'b0;
        w_m00_data      = '0;
        w_m00_keep      = '0;
        w_m01_load      = 1'b0;
        w_m01_data      = '0;
        w_m01_keep      = '0;
        w_m01_last      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (s_cfg_tvalid) begin
                    w_hlen_nxt  = w_cfg_len;
                    w_state_nxt = (w_cfg_len == '0) ? ST_BODY : ST_HDR;
                end
            end

            ST_HDR: begin
                s_axis_tready = w_m00_free && w_m01_free;
                if (w_s_hs) begin
                    w_m00_load   = 1'b1;
                    w_m00_data   = shr_bytes(w_din, DATA_BYTE_WD - 32'(w_hm));
                    w_m00_keep   = ones_lsb(w_hm);
                    w_resid_load = 1'b1;
                    if (!s_axis_tlast) begin
                        w_state_nxt = ST_BODY;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_hdr_err_nxt = (w_n < r_hlen);
                        if (w_n > r_hlen) begin
                            w_m01_load = 1'b1;
                            w_m01_data = shl_bytes(w_din, 32'(r_hlen));
                            w_m01_keep = ones_msb(w_n - r_hlen);
                            w_m01_last = 1'b1;
                        end
                    end
                end
            end

            ST_BODY: begin
                s_axis_tready = w_m01_free;
                if (w_s_hs) begin
                    w_m01_load = 1'b1;
                    if (w_pass) begin
                        w_m01_data = w_din;
                        w_m01_keep = s_axis_tkeep;
                        w_m01_last = s_axis_tlast;
                        if (s_axis_tlast) w_state_nxt = ST_IDLE;
                    end else begin
                        w_m01_data   = r_resid | shr_bytes(w_din, 32'(w_rlen));
                        w_m01_keep   = '1;
                        w_resid_load = 1'b1;
                        if (s_axis_tlast) begin
                            if (w_n <= r_hlen) begin
                                w_m01_keep  = ones_msb(w_rlen + w_n);
                                w_m01_last  = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                // Input bytes overflow this beat: one more beat follows
                                w_flush_len_nxt = w_n - r_hlen;
                                w_state_nxt     = ST_FLUSH;
                            end
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (w_m01_free) begin
                    w_m01_load  = 1'b1;
                    w_m01_data  = r_resid;
                    w_m01_keep  = ones_msb(r_flush_len);
                    w_m01_last  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so all
    // of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the residual buffer is a plain register, so it is cleared
            // along with everything else; a partial packet leaves no trace.
            r_hlen      <= '0;
            r_flush_len <= '0;
            r_resid     <= '0;
            r_hdr_err   <= 1'b0;
            r_m00_valid <= 1'b0;
            r_m00_data  <= '0;
            r_m00_keep  <= '0;
            r_m01_valid <= 1'b0;
            r_m01_data  <= '0;
            r_m01_keep  <= '0;
            r_m01_last  <= 1'b0;
        end else begin
            r_hlen      <= w_hlen_nxt;
            r_flush_len <= w_flush_len_nxt;
            r_hdr_err   <= w_hdr_err_nxt;
            if (w_resid_load) r_resid <= w_resid_nxt;

            if (w_m00_load) begin
                r_m00_valid <= 1'b1;
                r_m00_data  <= w_m00_data;
                r_m00_keep  <= w_m00_keep;
            end else if (m00_axis_tready) begin
                r_m00_valid <= 1'b0;
            end

            if (w_m01_load) begin
                r_m01_valid <= 1'b1;
                r_m01_data  <= w_m01_data;
                r_m01_keep  <= w_m01_keep;
                r_m01_last  <= w_m01_last;
            end else if (m01_axis_tready) begin
                r_m01_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// ---------------------------------------------------------------------------
// Testbench for axi_stream_extract_header (DATA_WD = 32).
// A byte-level reference model turns (H, packet bytes) into the expected
// header beat, payload beats and error pulse; directed scenarios also compare
// against literal beat values.
// ---------------------------------------------------------------------------
module tb_axi_stream_extract_header;

    localparam int DW  = 32;
    localparam int DBW = 4;
    localparam int LW  = 3;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [DBW-1:0] keep;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_cfg_tvalid;
    logic [LW-1:0]  s_cfg_tdata;
    logic           s_cfg_tready;
    logic           s_axis_tvalid;
    logic [DW-1:0]  s_axis_tdata;
    logic [DBW-1:0] s_axis_tkeep;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic           m00_axis_tvalid;
    logic [DW-1:0]  m00_axis_tdata;
    logic [DBW-1:0] m00_axis_tkeep;
    logic           m00_axis_tready = 1'b1;
    logic           m01_axis_tvalid;
    logic [DW-1:0]  m01_axis_tdata;
    logic [DBW-1:0] m01_axis_tkeep;
    logic           m01_axis_tlast;
    logic           m01_axis_tready = 1'b1;
    logic           hdr_err;

    always #5 clk = ~clk;

    axi_stream_extract_header #(.DATA_WD(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_cfg_tvalid    (s_cfg_tvalid),
        .s_cfg_tdata     (s_cfg_tdata),
        .s_cfg_tready    (s_cfg_tready),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tkeep  (m00_axis_tkeep),
        .m00_axis_tready (m00_axis_tready),
        .m01_axis_tvalid (m01_axis_tvalid),
        .m01_axis_tdata  (m01_axis_tdata),
        .m01_axis_tkeep  (m01_axis_tkeep),
        .m01_axis_tlast  (m01_axis_tlast),
        .m01_axis_tready (m01_axis_tready),
        .hdr_err         (hdr_err)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  pkt[$];
    beat_t       q_m00[$], q_m01[$], e_m00[$], e_m01[$];
    int          err_seen = 0;
    int          e_err = 0;
    int          stall_viol = 0;
    bit          rand_ready = 1'b0;
    bit          m01_hold = 1'b0;
    beat_t       p00, p01;
    logic        p00_v = 1'b0, p00_r = 1'b0, p01_v = 1'b0, p01_r = 1'b0;

    // Output monitor: chooses ready for the coming edge, then records the
    // handshakes that edge will complete. Also tracks output stability.
    always @(negedge clk) begin
        if (rst_n && p00_v && !p00_r &&
            !(m00_axis_tvalid && {m00_axis_tdata, m00_axis_tkeep, 1'b0} == p00))
            stall_viol++;
        if (rst_n && p01_v && !p01_r &&
            !(m01_axis_tvalid && {m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast} == p01))
            stall_viol++;
        m00_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        m01_axis_tready = m01_hold ? 1'b0 :
                          (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (rst_n && m00_axis_tvalid && m00_axis_tready)
            q_m00.push_back({m00_axis_tdata, m00_axis_tkeep, 1'b0});
        if (rst_n && m01_axis_tvalid && m01_axis_tready)
            q_m01.push_back({m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast});
        if (rst_n && hdr_err) err_seen++;
        p00_v = m00_axis_tvalid;
        p00_r = m00_axis_tready;
        p00   = {m00_axis_tdata, m00_axis_tkeep, 1'b0};
        p01_v = m01_axis_tvalid;
        p01_r = m01_axis_tready;
        p01   = {m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast};
    end

    // ---------------- stimulus helpers (called just after a negedge) -------
    task automatic drive_cfg(input logic [LW-1:0] h);
        int t = 0;
        s_cfg_tvalid = 1'b1;
        s_cfg_tdata  = h;
        #1;
        while (s_cfg_tready !== 1'b1 && t < 200) begin @(negedge clk); #1; t++; end
        checks++;
        if (t >= 200) begin errors++; $display("FAIL cfg_accept got=timeout exp=accepted"); end
        @(negedge clk);
        s_cfg_tvalid = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [DBW-1:0] k, input logic l);
        int t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        #1;
        while (s_axis_tready !== 1'b1 && t < 200) begin @(negedge clk); #1; t++; end
        checks++;
        if (t >= 200) begin errors++; $display("FAIL beat_accept got=timeout exp=accepted"); end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    // Sends cfg plus the bytes in pkt; unqualified lanes carry random garbage.
    task automatic send_packet(input int h_cfg);
        int nb = (pkt.size() + DBW - 1) / DBW;
        drive_cfg(LW'(h_cfg));
        for (int b = 0; b < nb; b++) begin
            logic [DW-1:0]  d;
            logic [DBW-1:0] k;
            for (int i = 0; i < DBW; i++) begin
                int idx = b * DBW + i;
                if (idx < pkt.size()) begin
                    d[DW-1-8*i -: 8] = pkt[idx];
                    k[DBW-1-i]       = 1'b1;
                end else begin
                    d[DW-1-8*i -: 8] = 8'($urandom);
                    k[DBW-1-i]       = 1'b0;
                end
            end
            drive_beat(d, k, b == nb - 1);
        end
    endtask

    // Reference model: header = first min(H, L) bytes right-aligned, payload
    // = bytes from H onward in MSB-aligned groups of DBW, error when L < H.
    task automatic build_expected(input int h_cfg);
        int    hl = (h_cfg > DBW) ? DBW : h_cfg;
        int    len = pkt.size();
        int    h = (len < hl) ? len : hl;
        beat_t bt;
        e_m00.delete();
        e_m01.delete();
        if (h > 0) begin
            bt = '0;
            for (int j = 0; j < h; j++) bt.data[8*(h-1-j) +: 8] = pkt[j];
            bt.keep = DBW'((1 << h) - 1);
            e_m00.push_back(bt);
        end
        for (int p = hl; p < len; p += DBW) begin
            bt = '0;
            for (int i = 0; i < DBW; i++)
                if (p + i < len) begin
                    bt.data[DW-1-8*i -: 8] = pkt[p+i];
                    bt.keep[DBW-1-i]       = 1'b1;
                end
            bt.last = (p + DBW >= len);
            e_m01.push_back(bt);
        end
        e_err = (len < hl) ? 1 : 0;
    endtask

    task automatic clear_obs();
        q_m00.delete();
        q_m01.delete();
        err_seen = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q_m00.size() < e_m00.size() || q_m01.size() < e_m01.size()) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (q_m00.size() != e_m00.size()) begin
            errors++;
            $display("FAIL %s m00_count got=%0d exp=%0d", tag, q_m00.size(), e_m00.size());
        end
        foreach (e_m00[i]) begin
            beat_t got = (i < q_m00.size()) ? q_m00[i] : '0;
            checks++;
            if (i >= q_m00.size() || got !== e_m00[i]) begin
                errors++;
                $display("FAIL %s m00[%0d] got=%h/%b exp=%h/%b", tag, i,
                         got.data, got.keep, e_m00[i].data, e_m00[i].keep);
            end
        end
        checks++;
        if (q_m01.size() != e_m01.size()) begin
            errors++;
            $display("FAIL %s m01_count got=%0d exp=%0d", tag, q_m01.size(), e_m01.size());
        end
        foreach (e_m01[i]) begin
            beat_t got = (i < q_m01.size()) ? q_m01[i] : '0;
            checks++;
            if (i >= q_m01.size() || got !== e_m01[i]) begin
                errors++;
                $display("FAIL %s m01[%0d] got=%h/%b/%b exp=%h/%b/%b", tag, i,
                         got.data, got.keep, got.last,
                         e_m01[i].data, e_m01[i].keep, e_m01[i].last);
            end
        end
        checks++;
        if (err_seen != e_err) begin
            errors++;
            $display("FAIL %s hdr_err_pulses got=%0d exp=%0d", tag, err_seen, e_err);
        end
    endtask

    task automatic run_packet(input int h_cfg, input string tag);
        clear_obs();
        build_expected(h_cfg);
        send_packet(h_cfg);
        drain();
        compare_model(tag);
    endtask

    task automatic load_bytes(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input int len);
        logic [3*DW-1:0] all = {w0, w1, w2};
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(all[3*DW-1-8*i -: 8]);
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        logic [8:0] got = {s_cfg_tready, s_axis_tready, m00_axis_tvalid, m01_axis_tvalid,
                           m01_axis_tlast, hdr_err, |m00_axis_tdata, |m01_axis_tdata,
                           |{m00_axis_tkeep, m01_axis_tkeep}};
        checks++;
        if (got !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=100000000", got);
        end
    endtask

    task automatic test_h2();
        beat_t lit[$];
        load_bytes(32'hAABBCCDD, 32'h11223344, 32'h55660000, 10);
        run_packet(2, "s1");
        checks++;
        if (q_m00.size() != 1 || q_m00[0] !== {32'h0000AABB, 4'b0011, 1'b0}) begin
            errors++;
            $display("FAIL s1_header got_count=%0d exp=0000AABB/0011", q_m00.size());
        end
        lit.push_back({32'hCCDD1122, 4'b1111, 1'b0});
        lit.push_back({32'h33445566, 4'b1111, 1'b1});
        foreach (lit[i]) begin
            beat_t got = (i < q_m01.size()) ? q_m01[i] : '0;
            checks++;
            if (got !== lit[i]) begin
                errors++;
                $display("FAIL s1_payload[%0d] got=%h exp=%h", i, got, lit[i]);
            end
        end
    endtask

    task automatic test_flush_h1();
        beat_t lit[$];
        load_bytes(32'hAABBCCDD, 32'h11223344, 32'h55667700, 11);
        run_packet(1, "s2");
        checks++;
        if (q_m00.size() != 1 || q_m00[0] !== {32'h000000AA, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL s2_header got_count=%0d exp=000000AA/0001", q_m00.size());
        end
        lit.push_back({32'hBBCCDD11, 4'b1111, 1'b0});
        lit.push_back({32'h22334455, 4'b1111, 1'b0});
        lit.push_back({32'h66770000, 4'b1100, 1'b1});
        foreach (lit[i]) begin
            beat_t got = (i < q_m01.size()) ? q_m01[i] : '0;
            checks++;
            if (got !== lit[i]) begin
                errors++;
                $display("FAIL s2_payload[%0d] got=%h exp=%h", i, got, lit[i]);
            end
        end
    endtask

    task automatic test_full_and_zero();
        load_bytes(32'h01020304, 32'h05060708, 32'h09000000, 9);
        run_packet(4, "s3_h4");
        checks++;
        if (q_m00.size() != 1 || q_m00[0] !== {32'h01020304, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL s3_h4_header got_count=%0d exp=01020304/1111", q_m00.size());
        end
        checks++;
        if (q_m01.size() != 2 || q_m01[1] !== {32'h09000000, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL s3_h4_tail got_count=%0d exp=09000000/1000/last", q_m01.size());
        end
        run_packet(0, "s3_h0");
        checks++;
        if (q_m01.size() != 3 || q_m01[0] !== {32'h01020304, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL s3_h0_first got_count=%0d exp=01020304/1111", q_m01.size());
        end
    endtask

    task automatic test_short_hdr_err();
        load_bytes(32'hAA000000, 32'h0, 32'h0, 1);
        clear_obs();
        build_expected(3);
        send_packet(3);
        checks++;
        if ({s_cfg_tready, hdr_err} !== 2'b11) begin
            errors++;
            $display("FAIL s4_after_last got cfg_tready,hdr_err=%b exp=11", {s_cfg_tready, hdr_err});
        end
        drain();
        compare_model("s4");
        checks++;
        if (q_m00.size() != 1 || q_m00[0] !== {32'h000000AA, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL s4_header got_count=%0d exp=000000AA/0001", q_m00.size());
        end
    endtask

    task automatic test_backpressure();
        load_bytes(32'hAABBCCDD, 32'h11223344, 32'h55660000, 10);
        clear_obs();
        build_expected(2);
        stall_viol = 0;
        fork
            send_packet(2);
            begin
                @(negedge clk);
                #2 m01_hold = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                checks++;
                if ({s_axis_tready, m01_axis_tvalid} !== 2'b01 || m01_axis_tdata !== 32'hCCDD1122) begin
                    errors++;
                    $display("FAIL s5_stalled got tready,valid=%b data=%h exp=01 CCDD1122",
                             {s_axis_tready, m01_axis_tvalid}, m01_axis_tdata);
                end
                repeat (3) @(negedge clk);
                #2 m01_hold = 1'b0;
            end
        join
        drain();
        compare_model("s5");
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL s5_stability got=%0d exp=0", stall_viol);
        end
    endtask

    task automatic test_reset_midpacket();
        clear_obs();
        drive_cfg(3'd1);
        drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        drive_beat(32'h11223344, 4'b1111, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h556677EE;
        s_axis_tkeep  = 4'b1110;
        s_axis_tlast  = 1'b1;
        #1;
        checks++;
        if (m01_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL s6_pre_reset_valid got=%b exp=1", m01_axis_tvalid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({m00_axis_tvalid, m01_axis_tvalid, s_axis_tready, s_cfg_tready, hdr_err} !== 5'b00010) begin
            errors++;
            $display("FAIL s6_async_reset got=%b exp=00010",
                     {m00_axis_tvalid, m01_axis_tvalid, s_axis_tready, s_cfg_tready, hdr_err});
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_cfg_tready, m01_axis_tvalid} !== 2'b10) begin
            errors++;
            $display("FAIL s6_after_release got=%b exp=10", {s_cfg_tready, m01_axis_tvalid});
        end
        pkt.delete();
        for (int i = 0; i < 9; i++) pkt.push_back(8'($urandom));
        run_packet(2, "s6_clean");
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        stall_viol = 0;
        for (int n = 0; n < 40; n++) begin
            int h   = $urandom_range(0, 7);
            int len = $urandom_range(1, 13);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            run_packet(h, $sformatf("rnd%0d_h%0d_l%0d", n, h, len));
        end
        rand_ready = 1'b0;
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL rnd_stability got=%0d exp=0", stall_viol);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        s_cfg_tvalid  = 1'b0;
        s_cfg_tdata   = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        test_h2();
        test_flush_h1();
        test_full_and_zero();
        test_short_hdr_err();
        test_backpressure();
        test_reset_midpacket();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
